// File: rtl/local_maxima_frame_feeder.sv
// Frame feeder for the local-maxima engine: buffers one SIDE x SIDE frame, then streams it in raster order and drives the flush cycles.
// Optional FRAME_FEEDER_LOOP_EN: a start seen in DONE restarts streaming directly, giving back-to-back frames.
module local_maxima_frame_feeder #(
  parameter int SIDE  = 6,
  parameter int PIX_W = 8,
  parameter int FLUSH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [5:0]       wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic [PIX_W-1:0] pix_out,
  output logic             pix_valid,
  output logic             pix_en,
  output logic [2:0]       row,
  output logic [2:0]       col,
  output logic             frame_start,
  output logic             frame_end,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam logic [5:0] LAST_IDX = 6'(SIDE * SIDE - 1);
  localparam logic [2:0] LAST_FC  = 3'(FLUSH - 1);
  localparam logic [2:0] LAST_COL = 3'(SIDE);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t           state, state_nx;
  logic [5:0]       idx, idx_nx;
  logic [2:0]       fc, fc_nx;
  logic [2:0]       row_nx, col_nx;
  logic             restart;
  logic             wr_ok;
  logic [PIX_W-1:0] rd_pix;
  logic [PIX_W-1:0] mem [SIDE*SIDE];

`ifdef FRAME_FEEDER_LOOP_EN
  assign restart = (state == S_DONE) && start;
`else
  assign restart = 1'b0;
`endif

  // Writes only land while no frame is in flight, so a streamed frame is never torn.
  assign wr_ok = wr_en && (wr_addr <= LAST_IDX) &&
                 ((state == S_IDLE) || ((state == S_DONE) && !restart));

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  // Forward a same-cycle write so write+start streams the new pixel.
  assign rd_pix = (wr_ok && (wr_addr == idx_nx)) ? wr_data : mem[idx_nx];

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    fc_nx    = fc;
    row_nx   = 3'd0;
    col_nx   = 3'd0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_STREAM;
          idx_nx   = 6'd0;
          row_nx   = 3'd1;
          col_nx   = 3'd1;
        end
      end
      S_STREAM: begin
        if (idx == LAST_IDX) begin
          state_nx = S_FLUSH;
          fc_nx    = 3'd0;
        end else begin
          idx_nx = idx + 6'd1;
          if (col == LAST_COL) begin
            row_nx = row + 3'd1;
            col_nx = 3'd1;
          end else begin
            row_nx = row;
            col_nx = col + 3'd1;
          end
        end
      end
      S_FLUSH: begin
        if (fc == LAST_FC) state_nx = S_DONE;
        else               fc_nx    = fc + 3'd1;
      end
      S_DONE: begin
        if (restart) begin
          state_nx = S_STREAM;
          idx_nx   = 6'd0;
          row_nx   = 3'd1;
          col_nx   = 3'd1;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= 6'd0;
      fc          <= 3'd0;
      row         <= 3'd0;
      col         <= 3'd0;
      pix_out     <= '0;
      pix_valid   <= 1'b0;
      pix_en      <= 1'b0;
      busy        <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      done        <= 1'b0;
    end else if (!stall) begin
      state       <= state_nx;
      idx         <= idx_nx;
      fc          <= fc_nx;
      row         <= row_nx;
      col         <= col_nx;
      pix_out     <= (state_nx == S_STREAM) ? rd_pix : '0;
      pix_valid   <= (state_nx == S_STREAM);
      pix_en      <= (state_nx == S_STREAM) || (state_nx == S_FLUSH);
      busy        <= (state_nx == S_STREAM) || (state_nx == S_FLUSH);
      frame_start <= (state_nx == S_STREAM) && (idx_nx == 6'd0);
      frame_end   <= (state_nx == S_STREAM) && (idx_nx == LAST_IDX);
      done        <= (state_nx == S_DONE);
    end
  end

  assign dbg_state = state;

endmodule

// File: doc/local_maxima_frame_feeder.md
# local_maxima_frame_feeder

Transmit side of the local-maxima pixel stream. Buffers one 6x6 frame of 8-bit pixels loaded over a random-access write port. On `start` it streams the frame in raster order, one pixel per cycle, then drives the pipeline-drain (flush) cycles the local-maxima engine needs. It sits between the host/memory side and the engine's `en`/`in` inputs, and tags every beat with 1-based row/col.

## Interface
- `SIDE`, 6: image side length; frame is SIDE*SIDE pixels.
- `PIX_W`, 8: pixel width.
- `FLUSH`, 7: drain cycles after the last pixel (SIDE+1).
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: frame-buffer write strobe.
- `wr_addr` in 6: raster address, 0..SIDE*SIDE-1.
- `wr_data` in PIX_W: pixel to write.
- `start` in 1: request transmission of the buffered frame.
- `stall` in 1: freeze all sequential state except buffer writes.
- `busy` out 1: high in STREAM and FLUSH.
- `pix_out` out PIX_W: streamed pixel; 0 outside STREAM.
- `pix_valid` out 1: `pix_out` carries a frame pixel.
- `pix_en` out 1: engine enable; high in STREAM and FLUSH.
- `row`, `col` out 3: 1-based position of the current pixel; 0 outside STREAM.
- `frame_start` out 1: pulse on pixel 0.
- `frame_end` out 1: pulse on pixel SIDE*SIDE-1.
- `done` out 1: one-cycle pulse after the last flush cycle.

## Operation
- States: IDLE, STREAM, FLUSH, DONE. Pixel counter `idx` is 0..35. Flush counter `fc` is 0..FLUSH-1.
- IDLE: `start`=1 loads `idx`=0 and moves to STREAM. Otherwise stays in IDLE.
- STREAM: drives `pix_out`=buf[idx], `pix_valid`=1, `pix_en`=1.
  - row = idx/SIDE+1, col = idx%SIDE+1. The divide is implemented as row/col counters: col wraps 6→1 and increments row.
  - At idx=35: go to FLUSH with `fc`=0.
- FLUSH: `pix_out`=0, `pix_valid`=0, `pix_en`=1, row=col=0. At `fc`=FLUSH-1: go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Writes are accepted only in IDLE or DONE. In STREAM and FLUSH they are dropped, which protects the frame in flight.
- Writes with `wr_addr` ≥ 36 are dropped.
- `start` outside IDLE is ignored, with no queuing.
- A write and `start` in the same IDLE cycle: the write commits, and the streamed frame contains the new data.
- `stall`=1 holds state, counters and all outputs at their current values. `pix_en` is also held, and the engine's own hold stalls it in lockstep. A `done` pulse is extended while stalled.
- `rst` mid-frame: returns to IDLE immediately and the current frame is abandoned. Buffer contents are retained (buffer is not reset).

## Timing
- Reset values: busy=0, pix_out=0, pix_valid=0, pix_en=0, row=col=0, frame_start=0, frame_end=0, done=0. State=IDLE.
- All outputs are registered.
- `start` sampled at edge t gives pixel 0 on cycle t+1 and pixel 35 on cycle t+36.
- Flush occupies cycles t+37..t+43. `done` is on cycle t+44.
- IDLE is re-entered at t+45, and the earliest next pixel 0 is at t+46.
- One frame = 43 `pix_en` cycles, matching the engine's 0..42 frame count.
- Stall cycles add 1:1 to every latency above.

## Configuration
- `FRAME_FEEDER_LOOP_EN` defined: if `start` is high during the DONE cycle, the feeder goes directly to STREAM with idx=0 (skipping IDLE), giving back-to-back frames with one gap cycle. Buffer writes remain blocked until a real IDLE/DONE with no restart.
- Undefined: DONE always returns to IDLE, and `start` in DONE is ignored.

## Test plan
- Load buf[i]=i+1 for all 36 pixels, then pulse `start` → pix_out runs 1..36 on cycles t+1..t+36 with row/col (1,1)..(6,6); frame_start at t+1, frame_end at t+36; 7 cycles of pix_en=1 with pix_valid=0; done at t+44.
- Write addr 5=0xAA during STREAM, and addr 40=0x55 in IDLE → next frame shows the old value at idx 5; no address aliases.
- Hold `stall` high for 3 cycles at idx=10 → pix_out=buf[10] and row/col=(2,5) held for 4 cycles; done shifts to t+47.
- Assert `rst` at idx=20 → next cycle: all outputs 0, busy=0; a following `start` streams the unchanged buffer from idx 0.
- Pulse `start` during FLUSH → ignored, and done arrives at t+44. Write addr 0=0x7F with `start` in the same cycle → first pixel = 0x7F.
- With `FRAME_FEEDER_LOOP_EN`: hold `start` high → pixel 0 of the second frame at t+45, done every 44 cycles. Without the macro: second pixel 0 at t+46.
